laa_exec_stage: RTL

Execute stage of the rv32 core, between decode and memory access. Accepts one decoded instruction per handshake and selects the ALU operands. Drives the combinational laa_alu, resolves branches and jumps, and registers the result into a one-entry EX/MEM output register. Produces a one-cycle redirect pulse to fetch/decode on a taken control transfer and discards the wrong-path instruction arriving in that cycle.

---
 rtl/laa_exec_stage_pkg.sv | 46 ++++
 rtl/laa_alu.sv | 40 ++++
 rtl/laa_exec_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/laa_exec_stage_pkg.sv
// ============================================================================
// laa_exec_stage_pkg : shared ALU op, instruction kind, branch and state codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package laa_exec_stage_pkg;

   typedef enum logic [3:0] {
      ALU_ADD                    = 4'd0,
      ALU_SUBTRACT               = 4'd1,
      ALU_LESS_THAN              = 4'd2,
      ALU_SIGNED_LESS_THAN       = 4'd3,
      ALU_AND                    = 4'd4,
      ALU_OR                     = 4'd5,
      ALU_XOR                    = 4'd6,
      ALU_SHIFT_LEFT             = 4'd7,
      ALU_SHIFT_RIGHT            = 4'd8,
      ALU_SHIFT_RIGHT_ARITHMETIC = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      KIND_ALU    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_JAL    = 2'd2,
      KIND_JALR   = 2'd3
   } kind_e;

   // funct3 encoding; codes 2 and 3 are unused and never taken
   typedef enum logic [2:0] {
      BR_EQ  = 3'd0,
      BR_NE  = 3'd1,
      BR_LT  = 3'd4,
      BR_GE  = 3'd5,
      BR_LTU = 3'd6,
      BR_GEU = 3'd7
   } br_cond_e;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_KILL = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/laa_alu.sv
// ============================================================================
// laa_alu : combinational integer ALU of the rv32 core
// Revision: 1.0
// ============================================================================
`default_nettype none

module laa_alu
   import laa_exec_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] alu_i_a,
   input  logic [XLEN-1:0] alu_i_b,
   input  logic [3:0]      alu_i_op,
   output logic [XLEN-1:0] alu_o
);

   logic [4:0] w_shamt;
   assign w_shamt = alu_i_b[4:0];

   always_comb begin
      alu_o = '0;
      case (alu_i_op)
         ALU_ADD:                    alu_o = alu_i_a + alu_i_b;
         ALU_SUBTRACT:               alu_o = alu_i_a - alu_i_b;
         ALU_LESS_THAN:              alu_o = {{(XLEN-1){1'b0}}, alu_i_a < alu_i_b};
         ALU_SIGNED_LESS_THAN:       alu_o = {{(XLEN-1){1'b0}}, $signed(alu_i_a) < $signed(alu_i_b)};
         ALU_AND:                    alu_o = alu_i_a & alu_i_b;
         ALU_OR:                     alu_o = alu_i_a | alu_i_b;
         ALU_XOR:                    alu_o = alu_i_a ^ alu_i_b;
         ALU_SHIFT_LEFT:             alu_o = alu_i_a << w_shamt;
         ALU_SHIFT_RIGHT:            alu_o = alu_i_a >> w_shamt;
         ALU_SHIFT_RIGHT_ARITHMETIC: alu_o = $unsigned($signed(alu_i_a) >>> w_shamt);
         default:                    alu_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/laa_exec_stage.sv
// ============================================================================
// laa_exec_stage : rv32 execute stage with branch resolution, redirect and
//                  one-entry EX/MEM output register
// Revision: 1.0
// ============================================================================
`default_nettype none

module laa_exec_stage
   import laa_exec_stage_pkg::*;
#(
   parameter int          XLEN         = 32,
   parameter logic [31:0] RESET_PC_TGT = 32'h0000_0000
) (
   input  logic            ex_i_clk,
   input  logic            ex_i_rst,
   input  logic            ex_i_flush,
   input  logic            ex_i_valid,
   output logic            ex_o_ready,
   input  logic [XLEN-1:0] ex_i_pc,
   input  logic [XLEN-1:0] ex_i_rs1,
   input  logic [XLEN-1:0] ex_i_rs2,
   input  logic [XLEN-1:0] ex_i_imm,
   input  logic [3:0]      ex_i_alu_op,
   input  logic            ex_i_sel_a,
   input  logic            ex_i_sel_b,
   input  logic [1:0]      ex_i_kind,
   input  logic [2:0]      ex_i_br_cond,
   input  logic [4:0]      ex_i_rd,
   input  logic            ex_i_rd_we,
   input  logic [3:0]      ex_i_mem_ctl,
   output logic            ex_o_valid,
   input  logic            ex_i_ready,
   output logic [XLEN-1:0] ex_o_result,
   output logic [XLEN-1:0] ex_o_store_data,
   output logic [4:0]      ex_o_rd,
   output logic            ex_o_rd_we,
   output logic [3:0]      ex_o_mem_ctl,
   output logic            ex_o_redir,
   output logic [XLEN-1:0] ex_o_redir_pc
);

   state_e            state_q, state_d;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [XLEN-1:0]   store_q, store_d;
   logic [4:0]        rd_q, rd_d;
   logic              rd_we_q, rd_we_d;
   logic [3:0]        mem_ctl_q, mem_ctl_d;
   logic              redir_q, redir_d;
   logic [XLEN-1:0]   redir_pc_q, redir_pc_d;

   logic [XLEN-1:0]   w_op_a, w_op_b, w_alu;
   logic [XLEN-1:0]   w_pc_plus4, w_target, w_jalr_sum;
   logic              w_cond, w_taken, w_accept;

   assign w_op_a = ex_i_sel_a ? ex_i_pc  : ex_i_rs1;
   assign w_op_b = ex_i_sel_b ? ex_i_imm : ex_i_rs2;

   laa_alu #(.XLEN(XLEN)) u_alu (
      .alu_i_a  (w_op_a),
      .alu_i_b  (w_op_b),
      .alu_i_op (ex_i_alu_op),
      .alu_o    (w_alu)
   );

   // Dedicated comparator so branch outcome does not depend on alu_op
   always_comb begin
      w_cond = 1'b0;
      case (ex_i_br_cond)
         BR_EQ:   w_cond = (ex_i_rs1 == ex_i_rs2);
         BR_NE:   w_cond = (ex_i_rs1 != ex_i_rs2);
         BR_LT:   w_cond = ($signed(ex_i_rs1) <  $signed(ex_i_rs2));
         BR_GE:   w_cond = ($signed(ex_i_rs1) >= $signed(ex_i_rs2));
         BR_LTU:  w_cond = (ex_i_rs1 <  ex_i_rs2);
         BR_GEU:  w_cond = (ex_i_rs1 >= ex_i_rs2);
         default: w_cond = 1'b0;
      endcase
   end

   assign w_pc_plus4 = ex_i_pc + XLEN'(4);
   assign w_jalr_sum = ex_i_rs1 + ex_i_imm;
   assign w_target   = (ex_i_kind == KIND_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0}
                                                : ex_i_pc + ex_i_imm;
   assign w_taken    = (ex_i_kind == KIND_JAL) || (ex_i_kind == KIND_JALR) ||
                       ((ex_i_kind == KIND_BRANCH) && w_cond);

   assign ex_o_ready = (!valid_q || ex_i_ready) && !ex_i_flush;
   assign w_accept   = ex_i_valid && ex_o_ready && (state_q == ST_RUN);

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      result_d   = result_q;
      store_d    = store_q;
      rd_d       = rd_q;
      rd_we_d    = rd_we_q;
      mem_ctl_d  = mem_ctl_q;
      redir_d    = 1'b0;
      redir_pc_d = redir_pc_q;

      if (valid_q && ex_i_ready) begin
         valid_d = 1'b0;
      end

      if (ex_i_flush) begin
         valid_d = 1'b0;
         state_d = ST_RUN;
      end else if (state_q == ST_KILL) begin
         // wrong-path instruction is consumed by the handshake but not stored
         state_d = ST_RUN;
      end else if (w_accept) begin
         valid_d   = 1'b1;
         result_d  = (ex_i_kind == KIND_JAL || ex_i_kind == KIND_JALR) ? w_pc_plus4 : w_alu;
         store_d   = ex_i_rs2;
         rd_d      = ex_i_rd;
         rd_we_d   = ex_i_rd_we && (ex_i_rd != 5'd0);
         mem_ctl_d = ex_i_mem_ctl;
         if (w_taken) begin
            state_d    = ST_KILL;
            redir_d    = 1'b1;
            redir_pc_d = w_target;
         end
      end
   end

   always_ff @(posedge ex_i_clk) begin
      if (ex_i_rst) begin
         state_q    <= ST_RUN;
         valid_q    <= 1'b0;
         result_q   <= '0;
         store_q    <= '0;
         rd_q       <= '0;
         rd_we_q    <= 1'b0;
         mem_ctl_q  <= '0;
         redir_q    <= 1'b0;
         redir_pc_q <= RESET_PC_TGT;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         result_q   <= result_d;
         store_q    <= store_d;
         rd_q       <= rd_d;
         rd_we_q    <= rd_we_d;
         mem_ctl_q  <= mem_ctl_d;
         redir_q    <= redir_d;
         redir_pc_q <= redir_pc_d;
      end
   end

   assign ex_o_valid      = valid_q;
   assign ex_o_result     = result_q;
   assign ex_o_store_data = store_q;
   assign ex_o_rd         = rd_q;
   assign ex_o_rd_we      = rd_we_q;
   assign ex_o_mem_ctl    = mem_ctl_q;
   assign ex_o_redir      = redir_q;
   assign ex_o_redir_pc   = redir_pc_q;

endmodule

`default_nettype wire
